hex_loader: RTL and testbench

Parametrised successor to the boot-time RAM loader in the Cortex-M0 DesignStart system. If loadButton is held on the first clock after reset, it takes ASCII hex lines from the UART receiver and writes DATA_WIDTH-bit words to block RAM. It adds `@` address records, recovery from errors, overflow protection, and a one-byte status reply to the UART transmitter over a valid/ready handshake.

---
 rtl/hex_loader_if.sv | 25 ++
 rtl/hex_loader.sv | 249 ++++++++++++++++++++++++
 tb/tb_hex_loader.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hex_loader_if.sv
// Bus bundle for hex_loader: UART receive strobe, block-RAM write port and
// the status-reply handshake towards the UART transmitter.
interface hex_loader_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int WADDR_WIDTH = 13
);
  logic [7:0]             rxByte;
  logic                   newByte;
  logic [WADDR_WIDTH-1:0] wAddr;
  logic [DATA_WIDTH-1:0]  wData;
  logic                   wNow;
  logic [7:0]             txByte;
  logic                   txValid;
  logic                   txReady;

  modport master (
    input  rxByte, newByte, txReady,
    output wAddr, wData, wNow, txByte, txValid
  );

  modport slave (
    output rxByte, newByte, txReady,
    input  wAddr, wData, wNow, txByte, txValid
  );
endinterface

// File: rtl/hex_loader.sv
// Boot-time RAM loader: parses ASCII hex lines and '@' address records from the
// UART, writes DATA_WIDTH-bit words to RAM and answers each record with 'K'/'E'.
module hex_loader #(
  parameter int DATA_WIDTH  = 32,
  parameter int WADDR_WIDTH = 13
) (
  input  logic         HCLK,
  input  logic         HRESETn,
  input  logic         loadButton,
  output logic         ROMload,
  output logic         loadError,
  hex_loader_if.master bus
);
  localparam int NIB  = DATA_WIDTH / 4;
  localparam int CW   = $clog2(NIB + 1);
  localparam int ADIG = (WADDR_WIDTH + 3) / 4;
  localparam int ACW  = $clog2(ADIG + 1);
  localparam int AW   = ADIG * 4;

  localparam logic [CW-1:0]  NIB_C  = CW'(NIB);
  localparam logic [ACW-1:0] ADIG_C = ACW'(ADIG);
  localparam logic [7:0]     REP_K  = 8'h4B;
  localparam logic [7:0]     REP_E  = 8'h45;

  typedef enum logic [2:0] {C_OTHER, C_ENDL, C_HEX, C_QUIT, C_AT} cls_t;
  typedef enum logic [2:0] {S_INIT, S_IDLE, S_ACTIVE, S_ADDR, S_ERROR} state_t;

  function automatic cls_t classify(input logic [7:0] b);
    cls_t c;
    c = C_OTHER;
    if (b == 8'h0A || b == 8'h0D)
      c = C_ENDL;
    else if ((b >= 8'h30 && b <= 8'h39) || (b >= 8'h41 && b <= 8'h46) ||
             (b >= 8'h61 && b <= 8'h66))
      c = C_HEX;
    else if (b == 8'h51 || b == 8'h71)
      c = C_QUIT;
    else if (b == 8'h40)
      c = C_AT;
    return c;
  endfunction

  function automatic logic [3:0] hexval(input logic [7:0] b);
    logic [3:0] v;
    if (b <= 8'h39)
      v = b[3:0];
    else
      v = b[3:0] + 4'd9;
    return v;
  endfunction

  state_t                 r_state;
  logic                   r_vld_p1;
  cls_t                   r_cls_p1;
  logic [3:0]             r_nib_p1;
  logic [DATA_WIDTH-1:0]  r_wdata;
  logic [CW-1:0]          r_ncnt;
  logic [WADDR_WIDTH-1:0] r_wcnt;
  logic                   r_full;
  logic [AW-1:0]          r_asr;
  logic [ACW-1:0]         r_acnt;
  logic [7:0]             r_txbyte;
  logic                   r_txvalid;
  logic                   r_err;

  state_t                 w_state_nxt;
  logic [DATA_WIDTH-1:0]  w_wdata_nxt;
  logic [CW-1:0]          w_ncnt_nxt;
  logic [WADDR_WIDTH-1:0] w_wcnt_nxt;
  logic                   w_full_nxt;
  logic [AW-1:0]          w_asr_nxt;
  logic [ACW-1:0]         w_acnt_nxt;
  logic                   w_wnow;
  logic                   w_rep;
  logic [7:0]             w_rep_byte;
  logic                   w_err;
  logic                   w_err_eol;

  // Stage p1: registered byte classification
  always_ff @(posedge HCLK) begin
    if (!HRESETn)
      r_vld_p1 <= 1'b0;
    else
      r_vld_p1 <= bus.newByte;
  end

  always_ff @(posedge HCLK) begin
    r_cls_p1 <= classify(bus.rxByte);
    r_nib_p1 <= hexval(bus.rxByte);
  end

  // Stage p2: parser FSM, Mealy on the registered decode
  always_comb begin
    w_state_nxt = r_state;
    w_wdata_nxt = r_wdata;
    w_ncnt_nxt  = r_ncnt;
    w_wcnt_nxt  = r_wcnt;
    w_full_nxt  = r_full;
    w_asr_nxt   = r_asr;
    w_acnt_nxt  = r_acnt;
    w_wnow      = 1'b0;
    w_rep       = 1'b0;
    w_rep_byte  = 8'h00;
    w_err       = 1'b0;
    w_err_eol   = 1'b0;
    case (r_state)
      S_INIT: w_state_nxt = loadButton ? S_ACTIVE : S_IDLE;
      S_ACTIVE: begin
        if (r_vld_p1) begin
          case (r_cls_p1)
            C_HEX: begin
              if (r_ncnt < NIB_C) begin
                w_wdata_nxt = {r_wdata[DATA_WIDTH-5:0], r_nib_p1};
                w_ncnt_nxt  = r_ncnt + CW'(1);
              end else begin
                w_err = 1'b1;
              end
            end
            C_ENDL: begin
              if (r_ncnt == NIB_C) begin
                if (!r_full) begin
                  w_wnow     = 1'b1;
                  w_ncnt_nxt = '0;
                  w_wcnt_nxt = r_wcnt + WADDR_WIDTH'(1);
                  w_full_nxt = (r_wcnt == '1);
                  w_rep      = 1'b1;
                  w_rep_byte = REP_K;
                end else begin
                  w_err_eol = 1'b1;
                end
              end else if (r_ncnt != '0) begin
                w_err_eol = 1'b1;
              end
            end
            C_AT: begin
              if (r_ncnt == '0) begin
                w_state_nxt = S_ADDR;
                w_asr_nxt   = '0;
                w_acnt_nxt  = '0;
              end else begin
                w_err = 1'b1;
              end
            end
            C_QUIT: begin
              if (r_ncnt == '0) begin
                w_state_nxt = S_IDLE;
                w_rep       = 1'b1;
                w_rep_byte  = REP_K;
              end else begin
                w_err = 1'b1;
              end
            end
            default: w_err = 1'b1;
          endcase
        end
      end
      S_ADDR: begin
        if (r_vld_p1) begin
          case (r_cls_p1)
            C_HEX: begin
              if (r_acnt == ADIG_C) begin
                w_err = 1'b1;
              end else begin
                w_asr_nxt  = (r_asr << 4) | AW'(r_nib_p1);
                w_acnt_nxt = r_acnt + ACW'(1);
              end
            end
            C_ENDL: begin
              if (r_acnt != '0) begin
                w_wcnt_nxt  = r_asr[WADDR_WIDTH-1:0];
                w_full_nxt  = 1'b0;
                w_rep       = 1'b1;
                w_rep_byte  = REP_K;
                w_state_nxt = S_ACTIVE;
              end else begin
                w_err_eol = 1'b1;
              end
            end
            default: w_err = 1'b1;
          endcase
        end
      end
      S_ERROR: begin
        if (r_vld_p1) begin
          if (r_cls_p1 == C_QUIT)
            w_state_nxt = S_IDLE;
          else if (r_cls_p1 == C_ENDL) begin
            w_state_nxt = S_ACTIVE;
            w_ncnt_nxt  = '0;
          end
        end
      end
      default: ;
    endcase
    // An error raised by a line terminator has already seen the end of the
    // line, so the loader resumes immediately instead of waiting for another.
    if (w_err || w_err_eol) begin
      w_state_nxt = w_err_eol ? S_ACTIVE : S_ERROR;
      w_ncnt_nxt  = '0;
      w_rep       = 1'b1;
      w_rep_byte  = REP_E;
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_state <= S_INIT;
      r_wdata <= '0;
      r_ncnt  <= '0;
      r_wcnt  <= '0;
      r_full  <= 1'b0;
      r_acnt  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wdata <= w_wdata_nxt;
      r_ncnt  <= w_ncnt_nxt;
      r_wcnt  <= w_wcnt_nxt;
      r_full  <= w_full_nxt;
      r_acnt  <= w_acnt_nxt;
      r_err   <= r_err | w_err | w_err_eol;
    end
  end

  always_ff @(posedge HCLK) begin
    r_asr <= w_asr_nxt;
  end

  // Stage p3: reply holding register; a pending reply wins over a new one
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_txvalid <= 1'b0;
      r_txbyte  <= 8'h00;
    end else if (w_rep && (!r_txvalid || bus.txReady)) begin
      r_txvalid <= 1'b1;
      r_txbyte  <= w_rep_byte;
    end else if (r_txvalid && bus.txReady) begin
      r_txvalid <= 1'b0;
    end
  end

  assign ROMload     = (r_state == S_ACTIVE) || (r_state == S_ADDR) || (r_state == S_ERROR);
  assign loadError   = r_err;
  assign bus.wNow    = w_wnow;
  assign bus.wAddr   = r_wcnt;
  assign bus.wData   = r_wdata;
  assign bus.txByte  = r_txbyte;
  assign bus.txValid = r_txvalid;
endmodule

// File: tb/tb_hex_loader.sv
// Bench for hex_loader: a 32-bit/8k-word instance and a 16-bit/16-word instance,
// both checked against a record-level model of the loader protocol.
module tb_hex_loader;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst32_n, rst16_n, btn32, btn16;
  logic rom32, rom16, err32, err16;

  hex_loader_if #(.DATA_WIDTH(32), .WADDR_WIDTH(13)) if32 ();
  hex_loader_if #(.DATA_WIDTH(16), .WADDR_WIDTH(4))  if16 ();

  hex_loader #(.DATA_WIDTH(32), .WADDR_WIDTH(13)) u32 (
    .HCLK(clk), .HRESETn(rst32_n), .loadButton(btn32),
    .ROMload(rom32), .loadError(err32), .bus(if32.master)
  );
  hex_loader #(.DATA_WIDTH(16), .WADDR_WIDTH(4)) u16 (
    .HCLK(clk), .HRESETn(rst16_n), .loadButton(btn16),
    .ROMload(rom16), .loadError(err16), .bus(if16.master)
  );

  int total = 0;
  int bad = 0;

  logic [79:0] gw0[$], gw1[$], ew0[$], ew1[$];
  logic [7:0]  gr0[$], gr1[$], er0[$], er1[$];

  always @(negedge clk) begin
    if (if32.wNow) gw0.push_back({16'(if32.wAddr), 64'(if32.wData)});
    if (if32.txValid && if32.txReady) gr0.push_back(if32.txByte);
    if (if16.wNow) gw1.push_back({16'(if16.wAddr), 64'(if16.wData)});
    if (if16.txValid && if16.txReady) gr1.push_back(if16.txByte);
  end

  localparam int M_IDLE = 0, M_ACT = 1, M_ADR = 2, M_ERR = 3;
  int NIBS[2]  = '{8, 4};
  int ADIGS[2] = '{4, 1};
  int AWS[2]   = '{13, 4};
  int     m_mode[2], m_nd[2], m_ad[2], m_addr[2], m_a[2];
  longint m_word[2];
  bit     m_full[2], m_lerr[2];

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_r(input int d, input logic [7:0] r);
    if (d == 0) er0.push_back(r); else er1.push_back(r);
  endtask

  task automatic m_fail(input int d, input bit eol);
    push_r(d, 8'h45);
    m_lerr[d] = 1'b1;
    m_nd[d]   = 0;
    m_word[d] = 0;
    m_mode[d] = eol ? M_ACT : M_ERR;
  endtask

  task automatic model(input int d, input logic [7:0] b);
    bit endl, hex, quit, at;
    int v;
    endl = (b == 8'h0A) || (b == 8'h0D);
    quit = (b == 8'h51) || (b == 8'h71);
    at   = (b == 8'h40);
    hex  = 1'b0;
    v    = 0;
    if (b >= 8'h30 && b <= 8'h39) begin hex = 1'b1; v = int'(b) - 48; end
    else if (b >= 8'h41 && b <= 8'h46) begin hex = 1'b1; v = int'(b) - 55; end
    else if (b >= 8'h61 && b <= 8'h66) begin hex = 1'b1; v = int'(b) - 87; end
    case (m_mode[d])
      M_ACT: begin
        if (hex) begin
          if (m_nd[d] < NIBS[d]) begin
            m_word[d] = m_word[d] * 16 + longint'(v);
            m_nd[d]++;
          end else m_fail(d, 1'b0);
        end else if (endl) begin
          if (m_nd[d] == NIBS[d]) begin
            if (m_full[d]) m_fail(d, 1'b1);
            else begin
              if (d == 0) ew0.push_back({16'(m_addr[d]), 64'(m_word[d])});
              else        ew1.push_back({16'(m_addr[d]), 64'(m_word[d])});
              push_r(d, 8'h4B);
              if (m_addr[d] == (1 << AWS[d]) - 1) begin
                m_full[d] = 1'b1;
                m_addr[d] = 0;
              end else m_addr[d]++;
              m_nd[d]   = 0;
              m_word[d] = 0;
            end
          end else if (m_nd[d] != 0) m_fail(d, 1'b1);
        end else if (at && m_nd[d] == 0) begin
          m_mode[d] = M_ADR;
          m_a[d]    = 0;
          m_ad[d]   = 0;
        end else if (quit && m_nd[d] == 0) begin
          push_r(d, 8'h4B);
          m_mode[d] = M_IDLE;
        end else m_fail(d, 1'b0);
      end
      M_ADR: begin
        if (hex) begin
          if (m_ad[d] == ADIGS[d]) m_fail(d, 1'b0);
          else begin
            m_a[d] = m_a[d] * 16 + v;
            m_ad[d]++;
          end
        end else if (endl && m_ad[d] > 0) begin
          m_addr[d] = m_a[d] % (1 << AWS[d]);
          m_full[d] = 1'b0;
          push_r(d, 8'h4B);
          m_mode[d] = M_ACT;
        end else m_fail(d, endl);
      end
      M_ERR: begin
        if (quit) m_mode[d] = M_IDLE;
        else if (endl) m_mode[d] = M_ACT;
      end
      default: ;
    endcase
  endtask

  task automatic drive(input int d, input logic [7:0] b, input logic s);
    if (d == 0) begin if32.rxByte = b; if32.newByte = s; end
    else begin if16.rxByte = b; if16.newByte = s; end
  endtask

  task automatic send(input int d, input logic [7:0] b);
    @(posedge clk); #1;
    drive(d, b, 1'b1);
    model(d, b);
    @(posedge clk); #1;
    drive(d, b, 1'b0);
    repeat ($urandom_range(0, 2)) @(posedge clk);
  endtask

  task automatic send_str(input int d, input string s);
    for (int i = 0; i < s.len(); i++) send(d, s[i]);
  endtask

  function automatic logic [7:0] rhex();
    int v;
    int base;
    v = $urandom_range(0, 15);
    base = ($urandom_range(0, 1) != 0) ? 97 : 65;
    if (v < 10) return 8'(48 + v);
    return 8'(base + v - 10);
  endfunction

  task automatic settle();
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic check_q(input int d, input string tag);
    logic [79:0] g[$], e[$];
    logic [7:0]  gr[$], xr[$];
    if (d == 0) begin
      g = gw0; e = ew0; gr = gr0; xr = er0;
      gw0.delete(); ew0.delete(); gr0.delete(); er0.delete();
    end else begin
      g = gw1; e = ew1; gr = gr1; xr = er1;
      gw1.delete(); ew1.delete(); gr1.delete(); er1.delete();
    end
    chk({tag, "_nwrites"}, 80'(g.size()), 80'(e.size()));
    for (int i = 0; i < g.size() && i < e.size(); i++)
      chk($sformatf("%s_write%0d", tag, i), g[i], e[i]);
    chk({tag, "_nreplies"}, 80'(gr.size()), 80'(xr.size()));
    for (int i = 0; i < gr.size() && i < xr.size(); i++)
      chk($sformatf("%s_reply%0d", tag, i), 80'(gr[i]), 80'(xr[i]));
    chk({tag, "_loadError"}, 80'((d == 0) ? err32 : err16), 80'(m_lerr[d]));
    chk({tag, "_ROMload"}, 80'((d == 0) ? rom32 : rom16), 80'(m_mode[d] != M_IDLE));
  endtask

  task automatic do_reset(input int d, input bit btn);
    @(posedge clk); #1;
    if (d == 0) begin rst32_n = 1'b0; btn32 = btn; if32.newByte = 1'b0; end
    else begin rst16_n = 1'b0; btn16 = btn; if16.newByte = 1'b0; end
    @(posedge clk); #1;
    if (d == 0) begin
      chk("rst_ctl", 80'({if32.wNow, if32.txValid, err32, rom32}), 80'(0));
      chk("rst_waddr", 80'(if32.wAddr), 80'(0));
      chk("rst_wdata", 80'(if32.wData), 80'(0));
      chk("rst_txbyte", 80'(if32.txByte), 80'(0));
      rst32_n = 1'b1;
    end else begin
      chk("rst_ctl", 80'({if16.wNow, if16.txValid, err16, rom16}), 80'(0));
      chk("rst_waddr", 80'(if16.wAddr), 80'(0));
      chk("rst_wdata", 80'(if16.wData), 80'(0));
      chk("rst_txbyte", 80'(if16.txByte), 80'(0));
      rst16_n = 1'b1;
    end
    m_mode[d] = btn ? M_ACT : M_IDLE;
    m_nd[d] = 0; m_ad[d] = 0; m_addr[d] = 0; m_a[d] = 0;
    m_word[d] = 0; m_full[d] = 1'b0; m_lerr[d] = 1'b0;
    if (d == 0) begin gw0.delete(); ew0.delete(); gr0.delete(); er0.delete(); end
    else begin gw1.delete(); ew1.delete(); gr1.delete(); er1.delete(); end
    @(posedge clk); #1;
    chk("init_ROMload", 80'((d == 0) ? rom32 : rom16), 80'(btn));
  endtask

  task automatic rand_lines(input int d, input int n);
    for (int k = 0; k < n; k++) begin
      int t, len;
      t = $urandom_range(0, 9);
      if (t < 5) begin
        for (int i = 0; i < NIBS[d]; i++) send(d, rhex());
        if ($urandom_range(0, 1) != 0) send(d, 8'h0D);
        send(d, 8'h0A);
      end else if (t == 5) begin
        send(d, 8'h40);
        len = $urandom_range(1, ADIGS[d]);
        for (int i = 0; i < len; i++) send(d, rhex());
        send(d, 8'h0A);
      end else if (t == 6) begin
        len = $urandom_range(1, NIBS[d] + 2);
        if (len == NIBS[d]) len++;
        for (int i = 0; i < len; i++) send(d, rhex());
        send(d, 8'h0A);
      end else if (t == 7) begin
        case ($urandom_range(0, 2))
          0: send(d, 8'h40);
          1: begin
            send(d, 8'h40);
            for (int i = 0; i <= ADIGS[d]; i++) send(d, rhex());
          end
          default: begin
            logic [7:0] junk[4];
            junk = '{8'h20, 8'h47, 8'h7A, 8'h23};
            send(d, junk[$urandom_range(0, 3)]);
          end
        endcase
        send(d, 8'h0A);
      end else begin
        send(d, ($urandom_range(0, 1) != 0) ? 8'h0D : 8'h0A);
      end
    end
  endtask

  initial begin
    rst32_n = 1'b0; rst16_n = 1'b0; btn32 = 1'b1; btn16 = 1'b1;
    if32.rxByte = 8'h00; if32.newByte = 1'b0; if32.txReady = 1'b1;
    if16.rxByte = 8'h00; if16.newByte = 1'b0; if16.txReady = 1'b1;
    do_reset(0, 1'b1);
    do_reset(1, 1'b1);

    // Two words, with a latency probe on the terminator of the first
    send_str(0, "DEADBEEF");
    @(posedge clk); #1;
    drive(0, 8'h0D, 1'b1);
    model(0, 8'h0D);
    @(posedge clk); #1;
    drive(0, 8'h0D, 1'b0);
    @(negedge clk);
    chk("lat_wnow", 80'(if32.wNow), 80'(1));
    chk("lat_waddr", 80'(if32.wAddr), 80'(0));
    chk("lat_wdata", 80'(if32.wData), 80'(32'hDEADBEEF));
    chk("lat_txvalid_early", 80'(if32.txValid), 80'(0));
    @(negedge clk);
    chk("lat_txvalid", 80'(if32.txValid), 80'(1));
    chk("lat_wnow_off", 80'(if32.wNow), 80'(0));
    chk("lat_waddr_inc", 80'(if32.wAddr), 80'(1));
    send(0, 8'h0A);
    send_str(0, "0000000A");
    send(0, 8'h0A);
    settle();
    check_q(0, "two_words");

    send_str(0, "@1F"); send(0, 8'h0A);
    send_str(0, "12345678"); send(0, 8'h0A);
    settle();
    chk("addr_after_1F", 80'(if32.wAddr), 80'(16'h20));
    check_q(0, "addr_rec");
    send(0, 8'h40); send(0, 8'h0A);
    settle();
    check_q(0, "empty_addr");

    send_str(0, "1234"); send(0, 8'h0A);
    send_str(0, "CAFEF00D"); send(0, 8'h0A);
    settle();
    check_q(0, "recover");

    rand_lines(0, 60);
    settle();
    check_q(0, "rand32");

    // Reply held back by the transmitter; the second reply is dropped
    send_str(0, "@0100"); send(0, 8'h0A);
    settle();
    check_q(0, "pre_hold");
    if32.txReady = 1'b0;
    send_str(0, "11111111"); send(0, 8'h0A);
    send_str(0, "22222222"); send(0, 8'h0A);
    settle();
    chk("hold_txvalid", 80'(if32.txValid), 80'(1));
    chk("hold_txbyte", 80'(if32.txByte), 80'(8'h4B));
    @(posedge clk); #1 if32.txReady = 1'b1;
    @(posedge clk); #1 if32.txReady = 1'b0;
    @(negedge clk);
    chk("hold_released", 80'(if32.txValid), 80'(0));
    if (er0.size() > 0) void'(er0.pop_back());
    if32.txReady = 1'b1;
    check_q(0, "hold");

    // Reset in the middle of a word with a reply still pending
    if32.txReady = 1'b0;
    send_str(0, "AAAAAAAA"); send(0, 8'h0A);
    send_str(0, "12");
    settle();
    chk("pending_before_rst", 80'(if32.txValid), 80'(1));
    er0.delete();
    check_q(0, "pre_rst");
    if32.txReady = 1'b1;
    do_reset(0, 1'b1);
    send_str(0, "55555555"); send(0, 8'h0A);
    settle();
    check_q(0, "post_rst");

    do_reset(0, 1'b0);
    send_str(0, "00000001"); send(0, 8'h0A);
    settle();
    check_q(0, "idle");

    rand_lines(1, 40);
    settle();
    check_q(1, "rand16");

    do_reset(1, 1'b1);
    for (int k = 0; k < 17; k++) begin
      for (int i = 0; i < 4; i++) send(1, rhex());
      send(1, 8'h0A);
    end
    settle();
    chk("full_error", 80'(err16), 80'(1));
    check_q(1, "full");
    send_str(1, "@0"); send(1, 8'h0A);
    settle();
    chk("full_cleared_addr", 80'(if16.wAddr), 80'(0));
    check_q(1, "clear_full");
    send_str(1, "BEEF"); send(1, 8'h0A);
    send(1, 8'h71); send(1, 8'h0A);
    settle();
    chk("beef_wdata", 80'(if16.wData), 80'(16'hBEEF));
    chk("quit_ROMload", 80'(rom16), 80'(0));
    check_q(1, "quit");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
